// File: rtl/sinaleira_pkg.sv
// Shared types and default timing for the two-street crossing scheduler.
package sinaleira_pkg;

    typedef enum logic [2:0] {
        TODOS_VERMELHO = 3'd0,
        R1_VERDE       = 3'd1,
        R1_AMARELO     = 3'd2,
        R2_VERDE       = 3'd3,
        R2_AMARELO     = 3'd4,
        PED_VERDE      = 3'd5
    } fase_t;

    typedef enum logic {
        RUA_1 = 1'b0,
        RUA_2 = 1'b1
    } rua_t;

    localparam int unsigned T_VERDE_MIN_DEF = 4;
    localparam int unsigned T_VERDE_MAX_DEF = 10;
    localparam int unsigned T_AMARELO_DEF   = 2;
    localparam int unsigned T_VERMELHO_DEF  = 1;
    localparam int unsigned T_PEDESTRE_DEF  = 5;
    localparam int unsigned CW_DEF          = 4;

    function automatic fase_t verde_de(rua_t rua);
        return (rua == RUA_1) ? R1_VERDE : R2_VERDE;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Per-phase tick counter: cleared on phase entry, advances on tick, saturates at all-ones.
module temporizador_fase #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          clear,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/escalonador_cruzamento.sv
// Actuated phase scheduler for a two-street crossing with a latched pedestrian phase.
module escalonador_cruzamento
    import sinaleira_pkg::*;
#(
    parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int unsigned T_VERDE_MAX = T_VERDE_MAX_DEF,
    parameter int unsigned T_AMARELO   = T_AMARELO_DEF,
    parameter int unsigned T_VERMELHO  = T_VERMELHO_DEF,
    parameter int unsigned T_PEDESTRE  = T_PEDESTRE_DEF,
    parameter int unsigned CW          = CW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor_1,
    input  logic       sensor_2,
    input  logic       pedestre,
    output logic       rua_1_vermelho,
    output logic       rua_1_amarelo,
    output logic       rua_1_verde,
    output logic       rua_2_vermelho,
    output logic       rua_2_amarelo,
    output logic       rua_2_verde,
    output logic       pedestre_vermelho,
    output logic       pedestre_verde,
    output logic [2:0] fase,
    output logic       pedido_pendente
);

    if (T_VERDE_MIN < 1 || T_VERDE_MAX < T_VERDE_MIN || T_AMARELO < 1 || T_VERMELHO < 1 ||
        T_PEDESTRE < 1 || T_VERDE_MAX >= 2**CW || T_PEDESTRE >= 2**CW ||
        T_AMARELO >= 2**CW || T_VERMELHO >= 2**CW) begin : g_param_invalido
        $error("escalonador_cruzamento: invalid timing parameters for CW");
    end

    // Timer value seen on the last tick of a phase lasting T ticks.
    localparam logic [CW-1:0] FIM_VERDE_MIN = CW'(T_VERDE_MIN - 1);
    localparam logic [CW-1:0] FIM_VERDE_MAX = CW'(T_VERDE_MAX - 1);
    localparam logic [CW-1:0] FIM_AMARELO   = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] FIM_VERMELHO  = CW'(T_VERMELHO - 1);
    localparam logic [CW-1:0] FIM_PEDESTRE  = CW'(T_PEDESTRE - 1);

    fase_t         fase_d, fase_q;
    rua_t          proxima_d, proxima_q;
    logic          pedido_d, pedido_q;
    logic [CW-1:0] timer;
    logic          entrada;

    temporizador_fase #(
        .CW (CW)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .clear (entrada),
        .count (timer)
    );

    always_comb begin
        fase_d    = fase_q;
        proxima_d = proxima_q;
        unique case (fase_q)
            TODOS_VERMELHO: begin
                if (tick && timer == FIM_VERMELHO) begin
                    fase_d = pedido_q ? PED_VERDE : verde_de(proxima_q);
                end
            end
            R1_VERDE: begin
                if (tick && (sensor_2 || pedido_q) &&
                    ((timer >= FIM_VERDE_MIN && !sensor_1) || timer >= FIM_VERDE_MAX)) begin
                    fase_d = R1_AMARELO;
                end
            end
            R1_AMARELO: begin
                if (tick && timer == FIM_AMARELO) begin
                    fase_d    = TODOS_VERMELHO;
                    proxima_d = RUA_2;
                end
            end
            R2_VERDE: begin
                if (tick && (sensor_1 || pedido_q) &&
                    ((timer >= FIM_VERDE_MIN && !sensor_2) || timer >= FIM_VERDE_MAX)) begin
                    fase_d = R2_AMARELO;
                end
            end
            R2_AMARELO: begin
                if (tick && timer == FIM_AMARELO) begin
                    fase_d    = TODOS_VERMELHO;
                    proxima_d = RUA_1;
                end
            end
            PED_VERDE: begin
                if (tick && timer == FIM_PEDESTRE) begin
                    fase_d = verde_de(proxima_q);
                end
            end
            default: fase_d = TODOS_VERMELHO;
        endcase
    end

    assign entrada = (fase_d != fase_q);

    // Entering the walk phase consumes the request and beats a coincident press.
    always_comb begin
        pedido_d = pedido_q;
        if (entrada && fase_d == PED_VERDE) begin
            pedido_d = 1'b0;
        end else if (fase_q != PED_VERDE && pedestre) begin
            pedido_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fase_q    <= TODOS_VERMELHO;
            proxima_q <= RUA_1;
            pedido_q  <= 1'b0;
        end else begin
            fase_q    <= fase_d;
            proxima_q <= proxima_d;
            pedido_q  <= pedido_d;
        end
    end

    always_comb begin
        rua_1_vermelho = 1'b1;
        rua_1_amarelo  = 1'b0;
        rua_1_verde    = 1'b0;
        rua_2_vermelho = 1'b1;
        rua_2_amarelo  = 1'b0;
        rua_2_verde    = 1'b0;
        pedestre_verde = 1'b0;
        unique case (fase_q)
            R1_VERDE:   begin rua_1_vermelho = 1'b0; rua_1_verde   = 1'b1; end
            R1_AMARELO: begin rua_1_vermelho = 1'b0; rua_1_amarelo = 1'b1; end
            R2_VERDE:   begin rua_2_vermelho = 1'b0; rua_2_verde   = 1'b1; end
            R2_AMARELO: begin rua_2_vermelho = 1'b0; rua_2_amarelo = 1'b1; end
            PED_VERDE:  pedestre_verde = 1'b1;
            default:    ;
        endcase
    end

    assign pedestre_vermelho = ~pedestre_verde;
    assign fase              = fase_q;
    assign pedido_pendente   = pedido_q;

endmodule
